mem_access_stage: RTL

Memory-access stage directly downstream of the ALU in the single-issue RV32I core. Takes the ALU result as the effective address and the rs2 operand as store data. Drives the synchronous data BRAM and the switch/LED MMIO region. Returns sign- or zero-extended load data to writeback, and stalls the PC/pipeline for the fixed load latency.

---
 rtl/mem_access_stage.sv | 138 +++++++++++++
 1 files changed

// File: rtl/mem_access_stage.sv
`default_nettype none
`timescale 1ns/1ps
`ifndef REGWIDTH
`define REGWIDTH 32
`endif
// mem_access_stage: RV32I memory-access stage for the data BRAM and switch/LED MMIO.
// Loads take three cycles (two stalled); stores complete in a single IDLE cycle.
module mem_access_stage #(
  parameter int unsigned RAM_ADDR_WIDTH = 14,
  parameter logic [31:0] IO_BASE        = 32'hFFFF_FC00
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      MemRead,
  input  logic                      MemWrite,
  input  logic [2:0]                funct3,
  input  logic [`REGWIDTH-1:0]      ALUResult,
  input  logic [`REGWIDTH-1:0]      ReadData2,
  output logic [RAM_ADDR_WIDTH-1:0] ram_addr,
  output logic [31:0]               ram_wdata,
  output logic [3:0]                ram_we,
  input  logic [31:0]               ram_rdata,
  input  logic [15:0]               switch_in,
  output logic [15:0]               led_out,
  output logic [`REGWIDTH-1:0]      MemData,
  output logic                      mem_valid,
  output logic                      mem_stall,
  output logic                      misaligned
);

  localparam logic [31:0] LED_ADDR = IO_BASE + 32'h60;
  localparam logic [31:0] SW_ADDR  = IO_BASE + 32'h70;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD_WAIT = 2'd1,
    LOAD_DONE = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [2:0]  lat_funct3;
  logic [1:0]  lat_off;
  logic        lat_io;
  logic        lat_sw;

  logic        ld_byte, ld_half, st_byte, st_half;
  logic        acc_byte, acc_half, aligned, is_io, store_ok;
  logic [31:0] rd_word, rd_shift, rd_ext;

  // Loads size on funct3[1:0] (bit 2 = unsigned); stores only know 000/001 as sub-word.
  assign ld_byte  = (funct3[1:0] == 2'b00);
  assign ld_half  = (funct3[1:0] == 2'b01);
  assign st_byte  = (funct3 == 3'b000);
  assign st_half  = (funct3 == 3'b001);
  assign acc_byte = MemRead ? ld_byte : st_byte;
  assign acc_half = MemRead ? ld_half : st_half;
  assign aligned  = acc_byte
                  | (acc_half & ~ALUResult[0])
                  | (~acc_byte & ~acc_half & (ALUResult[1:0] == 2'b00));
  assign is_io    = (ALUResult >= IO_BASE);
  assign store_ok = (state == IDLE) & MemWrite & ~MemRead & aligned;

  assign ram_addr  = ALUResult[RAM_ADDR_WIDTH+1:2];
  assign ram_wdata = st_byte ? {4{ReadData2[7:0]}} :
                     st_half ? {2{ReadData2[15:0]}} : ReadData2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    mem_stall  = 1'b0;
    mem_valid  = 1'b0;
    misaligned = 1'b0;
    ram_we     = 4'b0000;
    if (!rst) begin
      case (state)
        IDLE: begin
          misaligned = (MemRead | MemWrite) & ~aligned;
          if (MemRead && aligned) begin
            state_nxt = LOAD_WAIT;
            mem_stall = 1'b1;
          end else if (store_ok && !is_io) begin
            if (st_byte)      ram_we = 4'b0001 << ALUResult[1:0];
            else if (st_half) ram_we = ALUResult[1] ? 4'b1100 : 4'b0011;
            else              ram_we = 4'b1111;
          end
        end
        LOAD_WAIT: begin
          mem_stall = 1'b1;
          state_nxt = LOAD_DONE;
        end
        LOAD_DONE: begin
          mem_valid = 1'b1;
          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // IO reads are word-wide so sub-word loads of the switch register reuse the lane logic.
  always_comb begin
    rd_word  = lat_io ? (lat_sw ? {16'h0000, switch_in} : 32'h0) : ram_rdata;
    rd_shift = rd_word >> {lat_off, 3'b000};
    case (lat_funct3)
      3'b000:  rd_ext = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'b100:  rd_ext = {24'h0, rd_shift[7:0]};
      3'b001:  rd_ext = {{16{rd_shift[15]}}, rd_shift[15:0]};
      3'b101:  rd_ext = {16'h0, rd_shift[15:0]};
      default: rd_ext = rd_shift;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_funct3 <= 3'b000;
      lat_off    <= 2'b00;
      lat_io     <= 1'b0;
      lat_sw     <= 1'b0;
      MemData    <= '0;
      led_out    <= 16'h0000;
    end else begin
      if (state == IDLE) begin
        lat_funct3 <= funct3;
        lat_off    <= ALUResult[1:0];
        lat_io     <= is_io;
        lat_sw     <= ({ALUResult[31:2], 2'b00} == SW_ADDR);
      end
      if (state == LOAD_WAIT) MemData <= rd_ext;
      if (store_ok && ({ALUResult[31:2], 2'b00} == LED_ADDR)) led_out <= ReadData2[15:0];
    end
  end

endmodule
`default_nettype wire
